// File: rtl/srp16_wait_state_memory_if.sv
// Request/ready bus between the SRP16 core memory port and a wait-state memory.
// Addressing is word-based, and every request ends with a single ready pulse.
interface srp16_wait_state_memory_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;
    logic                  error;
    logic                  busy;

    modport master (
        output address,
        output write_data,
        output mem_read,
        output mem_write,
        input  read_data,
        input  ready,
        input  error,
        input  busy
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_read,
        input  mem_write,
        output read_data,
        output ready,
        output error,
        output busy
    );
endinterface

// File: rtl/srp16_wait_state_memory.sv
// Word-addressed RAM with a fixed number of wait states and a one-cycle ready pulse.
// Illegal requests still take the full latency, and then they complete with error set.
module srp16_wait_state_memory #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    srp16_wait_state_memory_if.slave bus
);
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WS_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rd_q;
    logic                  wr_q;
    logic                  legal_q;
    logic [DATA_WIDTH-1:0] read_data_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req;
    logic                  req_legal;
    logic                  accept;
    logic                  access;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_rd;
    logic                  acc_wr;
    logic                  acc_legal;

    // The range check uses the full address, so an alias above DEPTH never reaches the array.
    always_comb begin
        req       = bus.mem_read | bus.mem_write;
        req_legal = ({1'b0, bus.address} < DEPTH_EXT) && !(bus.mem_read && bus.mem_write);
        accept    = (state_q == ST_IDLE) && req;
        access    = ((state_q == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q <= 4'd1));
    end

    // With zero wait states the access edge is also the accept edge, so the live inputs are used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_idx   = bus.address[IDX_W-1:0];
            acc_wdata = bus.write_data;
            acc_rd    = bus.mem_read;
            acc_wr    = bus.mem_write;
            acc_legal = req_legal;
        end else begin
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_legal = legal_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            legal_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= bus.address[IDX_W-1:0];
                wdata_q <= bus.write_data;
                rd_q    <= bus.mem_read;
                wr_q    <= bus.mem_write;
                legal_q <= req_legal;
            end
            if (access) begin
                if (!acc_legal) begin
                    read_data_q <= '0;
                end else if (acc_rd) begin
                    read_data_q <= mem[acc_idx];
                end
                // The array itself is not reset. Reset only blocks a write that has not yet committed.
                if (acc_legal && acc_wr) begin
                    mem[acc_idx] <= acc_wdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.ready     = (state_q == ST_RESP);
        bus.error     = (state_q == ST_RESP) && !legal_q;
        bus.busy      = (state_q != ST_IDLE);
        bus.read_data = read_data_q;
    end
endmodule

// File: tb/tb_srp16_wait_state_memory.sv
// Scoreboard bench for three instances with zero, one and three wait states.
`timescale 1ns/1ps
module tb_srp16_wait_state_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [15:0] rdata [3];
    logic        rdy   [3];
    logic        err   [3];
    logic        bsy   [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        srp16_wait_state_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus_if ();
        srp16_wait_state_memory #(
            .DATA_WIDTH (16),
            .ADDR_WIDTH (16),
            .DEPTH      (4096),
            .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
        ) u_dut (
            .clk  (clk),
            .reset(rst[gi]),
            .bus  (bus_if)
        );
        assign bus_if.address    = addr[gi];
        assign bus_if.write_data = wdata[gi];
        assign bus_if.mem_read   = rd[gi];
        assign bus_if.mem_write  = wr[gi];
        assign rdata[gi]         = bus_if.read_data;
        assign rdy[gi]           = bus_if.ready;
        assign err[gi]           = bus_if.error;
        assign bsy[gi]           = bus_if.busy;
    end

    // Scoreboard: parallel queues, one entry per expected completion.
    int          q_dut  [$];
    int          q_cyc  [$];
    logic [15:0] q_data [$];
    bit          q_chk  [$];
    bit          q_err  [$];
    string       q_nm   [$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic push_exp(int k, int c, logic [15:0] d, bit chk, bit e, string nm);
        q_dut.push_back(k);
        q_cyc.push_back(c);
        q_data.push_back(d);
        q_chk.push_back(chk);
        q_err.push_back(e);
        q_nm.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (rdy[k] === 1'b1) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < q_dut.size(); j++) begin
                        if (idx < 0 && q_dut[j] == k) idx = j;
                    end
                    n_cmp++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL unexpected_ready dut%0d cyc=%0d: got ready=1, required no response", k, cyc);
                    end else begin
                        if (cyc != q_cyc[idx] || err[k] !== q_err[idx] ||
                            (q_chk[idx] && rdata[k] !== q_data[idx])) begin
                            n_fail++;
                            $display("FAIL %s dut%0d: got cyc=%0d err=%b data=%h, required cyc=%0d err=%b data=%h",
                                     q_nm[idx], k, cyc, err[k], rdata[k], q_cyc[idx], q_err[idx], q_data[idx]);
                        end else begin
                            $display("ok   %s dut%0d cyc=%0d err=%b data=%h", q_nm[idx], k, cyc, err[k], rdata[k]);
                        end
                        q_dut.delete(idx);
                        q_cyc.delete(idx);
                        q_data.delete(idx);
                        q_chk.delete(idx);
                        q_err.delete(idx);
                        q_nm.delete(idx);
                    end
                end else begin
                    n_cmp++;
                    if (err[k] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL err_outside_resp dut%0d cyc=%0d: got error=%b, required 0", k, cyc, err[k]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [31:0] got, logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // Issue one request from an IDLE cycle, hold it until ready, and return in the following IDLE cycle.
    task automatic issue(int k, bit r, bit w, logic [15:0] a, logic [15:0] d,
                         logic [15:0] exp_d, bit chk, bit exp_err, string nm);
        bit seen;
        check({nm, "_busy_before"}, 32'(bsy[k]), 32'd0);
        addr[k]  = a;
        wdata[k] = d;
        rd[k]    = r;
        wr[k]    = w;
        push_exp(k, cyc + ws_of(k) + 1, exp_d, chk, exp_err, nm);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            check({nm, "_busy"}, 32'(bsy[k]), 32'd1);
            if (rdy[k] === 1'b1) seen = 1'b1;
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready within 40 cycles, required ready", nm);
        end
        step();
        check({nm, "_busy_after"}, 32'(bsy[k]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        for (int k = 0; k < 3; k++) begin
            rst[k]   = 1'b0;
            rd[k]    = 1'b0;
            wr[k]    = 1'b0;
            addr[k]  = 16'h0000;
            wdata[k] = 16'h0000;
        end
        // Reset asserted asynchronously between clock edges
        #3;
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ready_dut%0d", k), 32'(rdy[k]), 32'd0);
            check($sformatf("reset_error_dut%0d", k), 32'(err[k]), 32'd0);
            check($sformatf("reset_busy_dut%0d", k), 32'(bsy[k]), 32'd0);
            check($sformatf("reset_rdata_dut%0d", k), 32'(rdata[k]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        step();
        mon_en = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("idle_busy_dut%0d", k), 32'(bsy[k]), 32'd0);
            check($sformatf("idle_rdata_dut%0d", k), 32'(rdata[k]), 32'd0);
        end

        // One wait state: basic write/read, illegal requests
        issue(1, 0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, 0, "ws1_write_beef");
        issue(1, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 0, "ws1_read_beef");
        issue(1, 0, 1, 16'h0000, 16'hA5A5, 16'h0000, 0, 0, "ws1_write_a5a5");
        issue(1, 0, 1, 16'h1000, 16'hDEAD, 16'h0000, 1, 1, "ws1_write_out_of_range");
        issue(1, 1, 0, 16'h0000, 16'h0000, 16'hA5A5, 1, 0, "ws1_read0_after_alias");
        issue(1, 1, 1, 16'h0010, 16'h7777, 16'h0000, 1, 1, "ws1_read_and_write");
        issue(1, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 0, "ws1_read_after_conflict");
        issue(1, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, "ws1_read_out_of_range");

        // Latency sweep on the zero and three wait-state instances
        issue(0, 0, 1, 16'h0030, 16'h1111, 16'h0000, 0, 0, "ws0_write");
        issue(0, 1, 0, 16'h0030, 16'h0000, 16'h1111, 1, 0, "ws0_read");
        issue(2, 0, 1, 16'h0040, 16'h2222, 16'h0000, 0, 0, "ws3_write");
        issue(2, 1, 0, 16'h0040, 16'h0000, 16'h2222, 1, 0, "ws3_read");

        // Held read: a new access every 3 cycles, and inputs scrambled during WAIT are ignored
        n0 = cyc;
        addr[1] = 16'h0010;
        rd[1]   = 1'b1;
        wr[1]   = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(1, n0 + 2 + 3 * i, 16'hBEEF, 1, 0, "ws1_held_read");
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 1 || j == 4) begin
                addr[1]  = 16'h0010;
                wdata[1] = 16'h0BAD;
                rd[1]    = 1'b0;
                wr[1]    = 1'b1;
            end else if (j == 2 || j == 5) begin
                rd[1] = 1'b1;
                wr[1] = 1'b0;
            end
        end
        rd[1] = 1'b0;
        step();
        check("ws1_held_read_busy_after", 32'(bsy[1]), 32'd0);
        issue(1, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 0, "ws1_read_after_held");

        // Reset during a three wait-state write: no ready and no commit
        issue(2, 0, 1, 16'h0020, 16'h5555, 16'h0000, 0, 0, "ws3_write_5555");
        addr[2]  = 16'h0020;
        wdata[2] = 16'h1234;
        wr[2]    = 1'b1;
        step();
        step();
        #3;
        rst[2] = 1'b1;
        wr[2]  = 1'b0;
        #1;
        check("midreset_ready", 32'(rdy[2]), 32'd0);
        check("midreset_busy", 32'(bsy[2]), 32'd0);
        check("midreset_rdata", 32'(rdata[2]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst[2] = 1'b0;
        step();
        check("midreset_busy_after_release", 32'(bsy[2]), 32'd0);
        issue(2, 1, 0, 16'h0020, 16'h0000, 16'h5555, 1, 0, "ws3_read_after_reset");

        repeat (5) step();
        n_cmp++;
        if (q_dut.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", q_dut.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
